// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the bus arbiter slice: FSM encoding, bus width and
// the index-width helper used by the arbiter, its picker and its interface.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int DATA_W = 8;

  // A single-requester-index still needs one bit so grant_id is never zero-width.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus drivers (master) and the arbiter (slave).
interface bus_arbiter_if import cpu_bus_pkg::*; #(
  parameter int NUM_REQ = 4
) ();
  localparam int IDW = arb_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               bus_busy;
  logic               timeout_err;

  modport master (output req, input grant, grant_id, bus_busy, timeout_err);
  modport slave  (input req, output grant, grant_id, bus_busy, timeout_err);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder; first set req bit at or
// above rr_ptr, wrapping from NUM_REQ-1 back to 0.
module rr_pick import cpu_bus_pkg::*; #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               valid
);
  int idx;

  // Walk from the farthest slot down so the nearest hit is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tristate bus arbiter with a turnaround gap between owners.
// Define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module bus_arbiter import cpu_bus_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);
  localparam int IDW = arb_idx_w(NUM_REQ);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_TURN  = TURN;

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         turn_cnt;
  logic [IDW-1:0]     winner;
  logic               valid;
  logic               owner_req;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (valid)
  );

  assign owner_req = bus.req[grant_id];

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant       <= '0;
      turn_cnt    <= '0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: if (valid) begin
          grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          grant_id <= winner;
          rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          hold_cnt <= 8'd1;
          state    <= S_GRANT;
        end
        S_GRANT: begin
          if (!owner_req) begin
            grant    <= '0;
            turn_cnt <= 2'd1;
            state    <= S_TURN;
          end else if (hold_cnt == 8'(MAX_HOLD)) begin
            grant       <= '0;
            turn_cnt    <= 2'd1;
            timeout_err <= 1'b1;
            state       <= S_TURN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_TURN: begin
          if (turn_cnt == 2'(TURN_CYCLES)) state <= S_IDLE;
          else                            turn_cnt <= turn_cnt + 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.timeout_err = timeout_err;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      grant    <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (valid) begin
          grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          grant_id <= winner;
          rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state    <= S_GRANT;
        end
        S_GRANT: if (!owner_req) begin
          grant    <= '0;
          turn_cnt <= 2'd1;
          state    <= S_TURN;
        end
        S_TURN: begin
          if (turn_cnt == 2'(TURN_CYCLES)) state <= S_IDLE;
          else                            turn_cnt <= turn_cnt + 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant    = grant;
  assign bus.grant_id = grant_id;
  assign bus.bus_busy = |grant;
endmodule
